// File: rtl/flash_wr_seq_pkg.sv
// Shared opcodes, sequencer state encoding and the region-index sizing
// helper used by the flash write sequencer and its bus interface.
package flash_pkg;

   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_PP   = 8'h02;
   localparam logic [7:0] OP_RDSR = 8'h05;
   localparam logic [7:0] OP_WRDI = 8'h04;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WREN,
      ST_PP,
      ST_RDSR,
      ST_WRDI,
      ST_FIN
   } state_t;

   // Width of a region index; a single region still needs one bit.
   function automatic int region_w(input int nreg);
      return (nreg > 1) ? $clog2(nreg) : 1;
   endfunction

endpackage

// File: rtl/flash_wr_seq_if.sv
// Control and SPI command-engine bus of the flash write sequencer.
// master: the sequencer; slave: the host plus SPI engine that drive it.
interface flash_wr_seq_if
   import flash_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 14,
   parameter int NREG   = 2
);

   localparam int RW = region_w(NREG);

   // host request side
   logic              start;
   logic [RW-1:0]     region;
   logic              abort;
   logic              busy;
   logic              done;
   logic              err;
   logic [RW-1:0]     region_q;

   // SPI command engine side
   logic              go;
   logic [7:0]        instr;
   logic [ADDR_W-1:0] adr;
   logic [CNT_W-1:0]  npix;
   logic              rd;
   logic              ack;
   logic              wip;

   modport master (
      input  start, region, abort, ack, wip,
      output go, instr, adr, npix, rd, busy, done, err, region_q
   );

   modport slave (
      output start, region, abort, ack, wip,
      input  go, instr, adr, npix, rd, busy, done, err, region_q
   );

endinterface

// File: rtl/flash_wr_seq.sv
// Flash write sequencer: for each word of the selected region issues
// WREN, PP, then polls RDSR until WIP clears, and closes with WRDI.
// Handles abort, WIP poll timeout and address overflow, and reports
// completion with a done pulse and a sticky err flag.
module flash_wr_seq
   import flash_pkg::*;
#(
   parameter int                     ADDR_W   = 16,
   parameter int                     CNT_W    = 14,
   parameter int                     NREG     = 2,
   parameter logic [NREG*ADDR_W-1:0] REG_BASE = {16'h00D0, 16'h5800},
   parameter logic [NREG*CNT_W-1:0]  REG_LEN  = {14'd5, 14'd5120},
   parameter int                     STEP     = 2,
   parameter int                     POLL_MAX = 1023
) (
   input logic            clk,
   input logic            reset,
   flash_wr_seq_if.master bus
);

   localparam int RW = region_w(NREG);
   // poll_cnt only ever holds 0 .. POLL_MAX-1; the POLL_MAX-th busy ack times out
   localparam int            PW        = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

   state_t            state_q;
   logic              go_q;
   logic [7:0]        instr_q;
   logic [ADDR_W-1:0] adr_q;
   logic [CNT_W-1:0]  npix_q;
   logic              rd_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic [RW-1:0]     reg_idx_q;
   logic              abort_q;
   logic [PW-1:0]     poll_cnt_q;

   logic              ack_ok;
   logic              abort_now;
   logic              region_ok;
   logic              last_word;
   logic              adr_ovf;
   logic [ADDR_W-1:0] base_sel;
   logic [CNT_W-1:0]  len_sel;
   logic [ADDR_W:0]   adr_inc;

   // ack during the go cycle belongs to nobody and is dropped
   assign ack_ok    = bus.ack & ~go_q;
   // an abort arriving with the ack itself counts for that ack
   assign abort_now = abort_q | bus.abort;
   assign region_ok = (int'(bus.region) < NREG);
   assign base_sel  = REG_BASE[int'(bus.region)*ADDR_W +: ADDR_W];
   assign len_sel   = REG_LEN[int'(reg_idx_q)*CNT_W +: CNT_W];
   assign last_word = (npix_q == len_sel - CNT_W'(1));
   assign adr_inc   = {1'b0, adr_q} + (ADDR_W+1)'(STEP);
   assign adr_ovf   = adr_inc[ADDR_W];

   // Sequencer FSM with all outputs registered.
   // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         go_q       <= 1'b0;
         instr_q    <= OP_WREN;
         adr_q      <= '0;
         npix_q     <= '0;
         rd_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         reg_idx_q  <= '0;
         abort_q    <= 1'b0;
         poll_cnt_q <= '0;
      end else begin
         go_q   <= 1'b0;
         done_q <= 1'b0;
         if (busy_q && bus.abort && state_q != ST_WRDI && state_q != ST_FIN) begin
            abort_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  if (region_ok) begin
                     reg_idx_q  <= bus.region;
                     adr_q      <= base_sel;
                     npix_q     <= '0;
                     err_q      <= 1'b0;
                     busy_q     <= 1'b1;
                     abort_q    <= 1'b0;
                     poll_cnt_q <= '0;
                     state_q    <= ST_WREN;
                     go_q       <= 1'b1;
                     instr_q    <= OP_WREN;
                  end else begin
                     err_q  <= 1'b1;
                     done_q <= 1'b1;
                  end
               end
            end
            ST_WREN: begin
               if (ack_ok) begin
                  go_q <= 1'b1;
                  if (abort_now) begin
                     state_q <= ST_WRDI;
                     instr_q <= OP_WRDI;
                  end else begin
                     state_q <= ST_PP;
                     instr_q <= OP_PP;
                  end
               end
            end
            ST_PP: begin
               if (ack_ok) begin
                  go_q <= 1'b1;
                  if (abort_now) begin
                     state_q <= ST_WRDI;
                     instr_q <= OP_WRDI;
                  end else begin
                     state_q <= ST_RDSR;
                     instr_q <= OP_RDSR;
                     rd_q    <= 1'b1;
                  end
               end
            end
            ST_RDSR: begin
               if (ack_ok) begin
                  go_q    <= 1'b1;
                  rd_q    <= 1'b0;
                  state_q <= ST_WRDI;
                  instr_q <= OP_WRDI;
                  if (bus.wip) begin
                     if (poll_cnt_q == POLL_LAST) begin
                        err_q <= 1'b1;
                     end else if (!abort_now) begin
                        // still busy: poll again
                        poll_cnt_q <= poll_cnt_q + PW'(1);
                        rd_q       <= 1'b1;
                        state_q    <= ST_RDSR;
                        instr_q    <= OP_RDSR;
                     end
                  end else begin
                     poll_cnt_q <= '0;
                     if (!last_word && !abort_now) begin
                        if (adr_ovf) begin
                           err_q <= 1'b1;
                        end else begin
                           npix_q  <= npix_q + CNT_W'(1);
                           adr_q   <= adr_inc[ADDR_W-1:0];
                           state_q <= ST_WREN;
                           instr_q <= OP_WREN;
                        end
                     end
                  end
               end
            end
            ST_WRDI: begin
               if (ack_ok) begin
                  state_q <= ST_FIN;
               end
            end
            ST_FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               abort_q <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.go       = go_q;
   assign bus.instr    = instr_q;
   assign bus.adr      = adr_q;
   assign bus.npix     = npix_q;
   assign bus.rd       = rd_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.region_q = reg_idx_q;

endmodule

// File: tb/tb_flash_wr_seq.sv
// Self-checking bench for flash_wr_seq. Acts as host and SPI engine,
// and compares every go pulse and every completion against a word-level
// model of the expected command stream.
module tb_flash_wr_seq;

   localparam int ADDR_W   = 16;
   localparam int CNT_W    = 14;
   localparam int NREG     = 3;
   localparam int STEP     = 2;
   localparam int POLL_MAX = 4;

   // region 2 sits at the top of the address space to reach overflow
   localparam logic [NREG*ADDR_W-1:0] BASES = {16'hFFFA, 16'h00D0, 16'h5800};
   localparam logic [NREG*CNT_W-1:0]  LENS  = {14'd6, 14'd5, 14'd5120};

   // model view of the same regions
   int base_tab [3] = '{32'h5800, 32'h00D0, 32'hFFFA};
   int len_tab  [3] = '{5120, 5, 6};

   typedef struct {
      int op;
      int adr;
      int npix;
      bit wip;
   } cmd_t;

   cmd_t exp_q [$];
   int   nbusy [0:5119];
   int   exp_err;
   int   n_assert = 0;
   int   n_fail   = 0;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   flash_wr_seq_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .NREG(NREG)) bus ();

   flash_wr_seq #(
      .ADDR_W  (ADDR_W),
      .CNT_W   (CNT_W),
      .NREG    (NREG),
      .REG_BASE(BASES),
      .REG_LEN (LENS),
      .STEP    (STEP),
      .POLL_MAX(POLL_MAX)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic cmd_t mk(input int op, input int adr, input int npix, input bit wip);
      cmd_t c;
      c.op   = op;
      c.adr  = adr;
      c.npix = npix;
      c.wip  = wip;
      return c;
   endfunction

   task automatic clear_busy();
      for (int i = 0; i < 5120; i++) nbusy[i] = 0;
   endtask

   // Expected command stream for one sequence: per word WREN, PP, then
   // nbusy[w] busy polls plus one ready poll (or POLL_MAX busy polls and
   // a timeout), ending in one WRDI. An abort at command abort_k cuts the
   // stream after that command.
   task automatic build_model(input int r, input int abort_k);
      int a;
      int err_idx;
      bit tmo;
      cmd_t wrdi;
      exp_q.delete();
      err_idx = -1;
      tmo     = 1'b0;
      for (int w = 0; w < len_tab[r]; w++) begin
         a = base_tab[r] + w * 2;
         exp_q.push_back(mk(32'h06, a, w, 1'b0));
         exp_q.push_back(mk(32'h02, a, w, 1'b0));
         if (nbusy[w] >= 4) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'h05, a, w, 1'b1));
            err_idx = exp_q.size() - 1;
            tmo     = 1'b1;
            exp_q.push_back(mk(32'h04, a, w, 1'b0));
            break;
         end
         for (int i = 0; i < nbusy[w]; i++) exp_q.push_back(mk(32'h05, a, w, 1'b1));
         exp_q.push_back(mk(32'h05, a, w, 1'b0));
         if (w == len_tab[r] - 1) begin
            exp_q.push_back(mk(32'h04, a, w, 1'b0));
            break;
         end
         if (a + 2 > 32'hFFFF) begin
            err_idx = exp_q.size() - 1;
            exp_q.push_back(mk(32'h04, a, w, 1'b0));
            break;
         end
      end
      exp_err = (err_idx >= 0) ? 1 : 0;
      if (abort_k >= 0 && abort_k < exp_q.size() - 1) begin
         if (abort_k < err_idx || (abort_k == err_idx && !tmo)) exp_err = 0;
         wrdi = mk(32'h04, exp_q[abort_k].adr, exp_q[abort_k].npix, 1'b0);
         while (exp_q.size() > abort_k + 1) void'(exp_q.pop_back());
         exp_q.push_back(wrdi);
      end
   endtask

   task automatic wait_go(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (bus.go === 1'b1) ok = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic recover();
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.ack   = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_go"},       bus.go,       0);
      check({tag, "_instr"},    bus.instr,    32'h06);
      check({tag, "_adr"},      bus.adr,      0);
      check({tag, "_npix"},     bus.npix,     0);
      check({tag, "_rd"},       bus.rd,       0);
      check({tag, "_busy"},     bus.busy,     0);
      check({tag, "_done"},     bus.done,     0);
      check({tag, "_err"},      bus.err,      0);
      check({tag, "_region_q"}, bus.region_q, 0);
   endtask

   // One full sequence: start region r, answer every go after lat cycles
   // (0 = random 1..3), pulse abort with command abort_k, optionally toggle
   // start/region while busy, and check the closing done pulse.
   task automatic run_seq(input int r, input int lat, input int abort_k, input bit noise,
                          output int n_go, output int n_rdsr, output int last_pp);
      bit   ok;
      int   lat_k;
      cmd_t c;
      build_model(r, abort_k);
      n_go    = 0;
      n_rdsr  = 0;
      last_pp = -1;
      // NOTE: stimulus is driven with blocking assignments at negedge, half a cycle clear of the sampling edge.
      bus.region = 2'(r);
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("start_go",       bus.go,       1);
      check("start_region_q", bus.region_q, r);
      check("start_err",      bus.err,      0);
      for (int k = 0; k < exp_q.size(); k++) begin
         wait_go(ok);
         check("go_seen", 32'(ok), 1);
         if (!ok) begin
            recover();
            return;
         end
         c = exp_q[k];
         check("cmd_instr", bus.instr, c.op);
         check("cmd_adr",   bus.adr,   c.adr);
         check("cmd_npix",  bus.npix,  c.npix);
         check("cmd_rd",    bus.rd,    (c.op == 32'h05) ? 1 : 0);
         check("cmd_busy",  bus.busy,  1);
         n_go++;
         if (c.op == 32'h05) n_rdsr++;
         if (c.op == 32'h02) last_pp = c.adr;
         if (k == abort_k) bus.abort = 1'b1;
         lat_k = (lat > 0) ? lat : int'($urandom_range(1, 3));
         for (int i = 1; i <= lat_k; i++) begin
            @(negedge clk);
            bus.abort = 1'b0;
            if (i == 1) check("go_width", bus.go, 0);
            bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) bus.region = 2'($urandom_range(0, 3));
            bus.ack = (i == lat_k);
            bus.wip = (i == lat_k) ? c.wip : 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         bus.ack   = 1'b0;
         bus.start = 1'b0;
         bus.wip   = 1'($urandom_range(0, 1));
      end
      c = exp_q[exp_q.size() - 1];
      check("fin_go",   bus.go,   0);
      check("fin_done", bus.done, 0);
      @(negedge clk);
      check("end_done",     bus.done,     1);
      check("end_busy",     bus.busy,     0);
      check("end_go",       bus.go,       0);
      check("end_err",      bus.err,      exp_err);
      check("end_adr",      bus.adr,      c.adr);
      check("end_npix",     bus.npix,     c.npix);
      check("end_region_q", bus.region_q, r);
      @(negedge clk);
      check("post_done", bus.done, 0);
      check("post_err",  bus.err,  exp_err);
   endtask

   initial begin
      int  n_go;
      int  n_rdsr;
      int  last_pp;
      int  gos;
      int  r;
      int  ak;
      bit  ok;

      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.region = '0;
      bus.abort  = 1'b0;
      bus.ack    = 1'b0;
      bus.wip    = 1'b0;
      clear_busy();
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b0;
      @(negedge clk);

      // region 1, every poll ready
      run_seq(1, 1, -1, 1'b0, n_go, n_rdsr, last_pp);
      check("r1_go_count", n_go,     16);
      check("r1_npix_end", bus.npix, 4);
      check("r1_adr_end",  bus.adr,  32'hD8);

      // region index out of range: error + done, stays idle, region_q kept
      bus.region = 2'd3;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("badreg_done",     bus.done,     1);
      check("badreg_err",      bus.err,      1);
      check("badreg_busy",     bus.busy,     0);
      check("badreg_go",       bus.go,       0);
      check("badreg_region_q", bus.region_q, 1);
      @(negedge clk);
      check("badreg_done_off", bus.done, 0);
      check("badreg_err_held", bus.err,  1);

      // region 0, all 5120 words
      run_seq(0, 2, -1, 1'b0, n_go, n_rdsr, last_pp);
      check("r0_go_count", n_go,    15361);
      check("r0_last_pp",  last_pp, 32'h7FFE);

      // three busy polls on word 2
      clear_busy();
      nbusy[2] = 3;
      run_seq(1, 1, -1, 1'b0, n_go, n_rdsr, last_pp);
      check("wip_rdsr_count", n_rdsr, 8);

      // poll timeout on word 1
      clear_busy();
      nbusy[1] = 10;
      run_seq(1, 1, -1, 1'b0, n_go, n_rdsr, last_pp);
      check("tmo_rdsr_count", n_rdsr,  5);
      check("tmo_go_count",   n_go,    10);
      check("tmo_err",        bus.err, 1);

      // abort during PP of word 1
      clear_busy();
      run_seq(1, 1, 4, 1'b0, n_go, n_rdsr, last_pp);
      check("abort_go_count", n_go,    6);
      check("abort_rdsr",     n_rdsr,  1);
      check("abort_err",      bus.err, 0);

      // abort on the timing-out poll
      clear_busy();
      nbusy[0] = 10;
      run_seq(1, 1, 5, 1'b0, n_go, n_rdsr, last_pp);
      check("abtmo_go_count", n_go,    7);
      check("abtmo_err",      bus.err, 1);

      // address overflow in region 2
      clear_busy();
      run_seq(2, 1, -1, 1'b0, n_go, n_rdsr, last_pp);
      check("ovf_go_count", n_go,     10);
      check("ovf_err",      bus.err,  1);
      check("ovf_adr",      bus.adr,  32'hFFFE);
      check("ovf_npix",     bus.npix, 2);

      // start/region toggled while busy
      run_seq(1, 0, -1, 1'b1, n_go, n_rdsr, last_pp);
      check("noise_region_q", bus.region_q, 1);

      // randomized sequences
      for (int t = 0; t < 10; t++) begin
         clear_busy();
         for (int w = 0; w < 6; w++) begin
            nbusy[w] = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, 2));
         end
         r  = int'($urandom_range(1, 2));
         ak = (r == 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
         run_seq(r, 0, ak, 1'($urandom_range(0, 1)), n_go, n_rdsr, last_pp);
      end

      // reset while an RDSR is in flight
      clear_busy();
      bus.region = 2'd1;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int j = 0; j < 2; j++) begin
         wait_go(ok);
         @(negedge clk);
         bus.ack = 1'b1;
         @(negedge clk);
         bus.ack = 1'b0;
      end
      wait_go(ok);
      check("rst_rdsr_instr", bus.instr, 32'h05);
      check("rst_rdsr_rd",    bus.rd,    1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_vals("rst_mid");
      gos = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.go === 1'b1) gos++;
      end
      check("rst_no_wrdi", gos, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
